// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
// Contents: op encodings, FSM state constants, iteration count,
// divide-by-zero quotient and a two's-complement magnitude helper.
package muldiv_pkg;

    // Op[1] selects divide, Op[0] selects signed.
    localparam logic [1:0] MULDIV_MULTU = 2'b00;
    localparam logic [1:0] MULDIV_MULT  = 2'b01;
    localparam logic [1:0] MULDIV_DIVU  = 2'b10;
    localparam logic [1:0] MULDIV_DIV   = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIX  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam int ITERATIONS = 32;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    // Magnitude of a 32-bit value; 0x80000000 maps to itself, which is
    // exactly the unsigned magnitude the datapath needs.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when to register the result.
// Ports: is_div selects divide, acc_in/acc_out is the 64-bit
//   {partial, shifting operand} register, operand is the multiplicand or
//   divisor magnitude, q_bit is the quotient bit produced this step.
// Build option: MULDIV_DIV_EN keeps the divide path; otherwise only multiply.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        is_div,
    input  logic [63:0] acc_in,
    input  logic [31:0] operand,
    output logic [63:0] acc_out,
    output logic        q_bit
);

    // Multiply: acc = {partial product high, remaining multiplier bits}.
    // Add the multiplicand into the top half when the current multiplier
    // bit is set, then shift the whole 65-bit result right by one.
    logic [32:0] mul_sum;
    logic [63:0] mul_acc;

    always_comb begin
        mul_sum = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, operand} : 33'd0);
        mul_acc = {mul_sum, acc_in[31:1]};
    end

`ifdef MULDIV_DIV_EN
    // Divide: acc = {remainder, dividend bits still to shift in}.
    // The 33-bit partial remainder is the old remainder shifted left with
    // the next dividend bit; a borrow in the trial subtract restores it.
    logic [32:0] part_rem;
    logic [33:0] trial;
    logic [31:0] new_rem;
    logic        q_raw;

    always_comb begin
        part_rem = {acc_in[63:32], acc_in[31]};
        trial    = {1'b0, part_rem} - {2'b00, operand};
        q_raw    = ~trial[33];
        // On restore the partial remainder is below the divisor, so its
        // top bit is zero and dropping it loses nothing.
        new_rem  = q_raw ? trial[31:0] : part_rem[31:0];
        acc_out  = is_div ? {new_rem, acc_in[30:0], 1'b0} : mul_acc;
        q_bit    = is_div & q_raw;
    end
`else
    logic unused_is_div;
    assign unused_is_div = is_div;

    always_comb begin
        acc_out = mul_acc;
        q_bit   = 1'b0;
    end
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair.
// Latency: 33 edges from the Start edge to valid HI/LO; Done pulses the cycle after.
// Backpressure: Busy high in RUN/FIX; Start and MTHI/MTLO writes are ignored while Busy.
// Ports: clk, rst (async, active-high), Start/Op/A/B issue an operation,
//   Wr_Hi/Wr_Lo/WD are MTHI/MTLO, Busy/Done status, HI/LO result registers.
// Build option: MULDIV_DIV_EN enables the divider; without it divide
//   starts are dropped and only multiply is available.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Wr_Hi,
    input  logic        Wr_Lo,
    input  logic [31:0] WD,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [1:0]  op_q, op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] step_acc;
    logic        step_q;

    muldiv_step u_step (
        .is_div  (op_q[1]),
        .acc_in  (acc_q),
        .operand (opnd_q),
        .acc_out (step_acc),
        .q_bit   (step_q)
    );

    logic        idle_or_done;
    logic        start_ok;
    logic        neg_a, neg_b;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    always_comb begin
        idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
`ifdef MULDIV_DIV_EN
        start_ok = Start & idle_or_done;
`else
        start_ok = Start & idle_or_done & ~Op[1];
`endif
        neg_a = Op[0] & A[31];
        neg_b = Op[0] & B[31];
        a_mag = mag32(A, neg_a);
        b_mag = mag32(B, neg_b);

        // Sign correction applied in FIX.
        prod = (op_q[0] && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
        quo  = acc_q[31:0];
        rem  = acc_q[63:32];
        if (opnd_q == 32'd0) begin
            // Divide by zero: all-ones quotient, no quotient sign fix;
            // the remainder fix below restores the original dividend.
            quo = DIV0_QUOTIENT;
        end else if (sign_a_q ^ sign_b_q) begin
            quo = -quo;
        end
        if (sign_a_q) begin
            rem = -rem;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Wr_Hi) hi_d = WD;
                if (Wr_Lo) lo_d = WD;
                if (start_ok) begin
                    state_d  = ST_RUN;
                    cnt_d    = 5'd0;
                    op_d     = Op;
                    sign_a_d = neg_a;
                    sign_b_d = neg_b;
                    if (Op[1]) begin
                        // Divide: dividend shifts out of the low half.
                        acc_d  = {32'd0, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        // Multiply: multiplier shifts out of the low half.
                        acc_d  = {32'd0, b_mag};
                        opnd_d = a_mag;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // The step leaves the divide LSB free for the quotient bit.
                acc_d = op_q[1] ? {step_acc[63:1], step_q} : step_acc;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
`else
                hi_d = prod[63:32];
                lo_d = prod[31:0];
`endif
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            op_q     <= MULDIV_MULTU;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign Busy = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign Done = (state_q == ST_DONE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, random ops
// against an arithmetic reference model, and control-path scenarios.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A, B;
    logic        Wr_Hi, Wr_Lo;
    logic [31:0] WD;
    logic        Busy, Done;
    logic [31:0] HI, LO;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Wr_Hi (Wr_Hi),
        .Wr_Lo (Wr_Lo),
        .WD    (WD),
        .Busy  (Busy),
        .Done  (Done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    // Reference: returns {HI, LO} from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0: p = {32'd0, a} * {32'd0, b};
            2'd1: p = 64'(sa * sb);
            2'd2: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p = {sr[31:0], sq[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    // Counts cycles after the Start edge until Done; -1 on timeout.
    task automatic wait_done(output int done_at, output int busy_cnt);
        done_at  = -1;
        busy_cnt = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (Busy) busy_cnt++;
            if (Done) begin
                done_at = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; Start = 1'b0; Op = 2'd0; A = '0; B = '0;
        Wr_Hi = 1'b0; Wr_Lo = 1'b0; WD = '0;
        #1;
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", Busy); end
        n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", Done); end
        n_tests++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", HI); end
        n_tests++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", LO); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_directed;
        vec_t vq[$];
        int done_at, busy_cnt;
        vq.push_back('{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vq.push_back('{2'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
`ifdef MULDIV_DIV_EN
        vq.push_back('{2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vq.push_back('{2'd2, 32'd100, 32'd7, 32'd2, 32'd14});
        vq.push_back('{2'd2, 32'h64, 32'd0, 32'h64, 32'hFFFF_FFFF});
        vq.push_back('{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000});
        vq.push_back('{2'd3, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
`endif
        foreach (vq[i]) begin
            start_op(vq[i].op, vq[i].a, vq[i].b);
            wait_done(done_at, busy_cnt);
            n_tests++; if (done_at != 34) begin n_fail++; $display("FAIL dir%0d_done_cycle got %0d want 34", i, done_at); end
            n_tests++; if (busy_cnt != 33) begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d want 33", i, busy_cnt); end
            n_tests++; if (HI !== vq[i].hi) begin n_fail++; $display("FAIL dir%0d_hi got %h want %h", i, HI, vq[i].hi); end
            n_tests++; if (LO !== vq[i].lo) begin n_fail++; $display("FAIL dir%0d_lo got %h want %h", i, LO, vq[i].lo); end
        end
    endtask

    task automatic test_random;
        int done_at, busy_cnt, sel;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
`ifdef MULDIV_DIV_EN
            op = 2'($urandom_range(0, 3));
`else
            op = 2'($urandom_range(0, 1));
`endif
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = $urandom_range(1, 15);
            if (sel == 3) a = 32'($urandom_range(0, 5)) - 32'd2;
            exp = model(op, a, b);
            start_op(op, a, b);
            wait_done(done_at, busy_cnt);
            n_tests++; if (done_at != 34) begin n_fail++; $display("FAIL rnd%0d_done_cycle got %0d want 34", i, done_at); end
            n_tests++; if (HI !== exp[63:32]) begin n_fail++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, op, a, b, HI, exp[63:32]); end
            n_tests++; if (LO !== exp[31:0]) begin n_fail++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, op, a, b, LO, exp[31:0]); end
        end
    endtask

    task automatic test_start_in_run;
        int done_at, busy_cnt;
        start_op(2'd0, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        Start = 1'b1; Op = 2'd0; A = 32'd9; B = 32'd9;
        @(posedge clk);
        #1 Start = 1'b0;
        wait_done(done_at, busy_cnt);
        n_tests++; if (done_at != 28) begin n_fail++; $display("FAIL start_in_run_done_cycle got %0d want 28", done_at); end
        n_tests++; if (LO !== 32'd3000) begin n_fail++; $display("FAIL start_in_run_lo got %h want %h", LO, 32'd3000); end
        n_tests++; if (HI !== 32'd0) begin n_fail++; $display("FAIL start_in_run_hi got %h want 0", HI); end
    endtask

    task automatic test_reset_mid_run;
        int done_at, busy_cnt;
        start_op(2'd0, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", Busy); end
        n_tests++; if (HI !== 32'd0) begin n_fail++; $display("FAIL midrst_hi got %h want 0", HI); end
        n_tests++; if (LO !== 32'd0) begin n_fail++; $display("FAIL midrst_lo got %h want 0", LO); end
        @(posedge clk);
        #1 rst = 1'b0;
        start_op(2'd0, 32'd3, 32'd4);
        wait_done(done_at, busy_cnt);
        n_tests++; if (done_at != 34) begin n_fail++; $display("FAIL after_rst_done_cycle got %0d want 34", done_at); end
        n_tests++; if (LO !== 32'd12) begin n_fail++; $display("FAIL after_rst_lo got %h want c", LO); end
    endtask

    task automatic test_wr_hilo;
        int done_at, busy_cnt;
        @(posedge clk);
        #1 Wr_Lo = 1'b1; WD = 32'h1234;
        @(posedge clk);
        #1 Wr_Lo = 1'b0;
        n_tests++; if (LO !== 32'h1234) begin n_fail++; $display("FAIL mtlo got %h want 1234", LO); end
        Wr_Hi = 1'b1; WD = 32'hAAAA;
        @(posedge clk);
        #1 Wr_Hi = 1'b0;
        n_tests++; if (HI !== 32'hAAAA) begin n_fail++; $display("FAIL mthi got %h want aaaa", HI); end
        start_op(2'd0, 32'd5, 32'd7);
        @(posedge clk);
        #1 Wr_Hi = 1'b1; WD = 32'h5555;
        @(posedge clk);
        #1 Wr_Hi = 1'b0;
        n_tests++; if (HI !== 32'hAAAA) begin n_fail++; $display("FAIL mthi_in_run got %h want aaaa", HI); end
        wait_done(done_at, busy_cnt);
        n_tests++; if (HI !== 32'd0) begin n_fail++; $display("FAIL mthi_in_run_result_hi got %h want 0", HI); end
        n_tests++; if (LO !== 32'd35) begin n_fail++; $display("FAIL mthi_in_run_result_lo got %h want 23", LO); end
        // Write and Start together: write lands first, result overwrites.
        @(posedge clk);
        #1;
        Wr_Lo = 1'b1; WD = 32'hBEEF; Start = 1'b1; Op = 2'd0; A = 32'd6; B = 32'd7;
        @(posedge clk);
        #1 Wr_Lo = 1'b0; Start = 1'b0;
        n_tests++; if (LO !== 32'hBEEF) begin n_fail++; $display("FAIL wr_with_start_lo got %h want beef", LO); end
        wait_done(done_at, busy_cnt);
        n_tests++; if (LO !== 32'd42) begin n_fail++; $display("FAIL wr_with_start_result got %h want 2a", LO); end
    endtask

    task automatic test_back_to_back;
        int done_at, busy_cnt;
        logic [63:0] exp;
        start_op(2'd1, 32'hFFFF_FF00, 32'd77);
        wait_done(done_at, busy_cnt);
        exp = model(2'd1, 32'hFFFF_FF00, 32'd77);
        n_tests++; if ({HI, LO} !== exp) begin n_fail++; $display("FAIL b2b_first got %h want %h", {HI, LO}, exp); end
        // Issue the next op while still in DONE.
        Start = 1'b1; Op = 2'd0; A = 32'h0001_0001; B = 32'h0002_0003;
        @(posedge clk);
        #1 Start = 1'b0;
        wait_done(done_at, busy_cnt);
        exp = model(2'd0, 32'h0001_0001, 32'h0002_0003);
        n_tests++; if (done_at != 34) begin n_fail++; $display("FAIL b2b_done_cycle got %0d want 34", done_at); end
        n_tests++; if (busy_cnt != 33) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d want 33", busy_cnt); end
        n_tests++; if ({HI, LO} !== exp) begin n_fail++; $display("FAIL b2b_second got %h want %h", {HI, LO}, exp); end
    endtask

`ifndef MULDIV_DIV_EN
    task automatic test_div_disabled;
        int done_at, busy_cnt;
        logic saw_busy, saw_done;
        @(posedge clk);
        #1 Wr_Hi = 1'b1; Wr_Lo = 1'b1; WD = 32'h11;
        @(posedge clk);
        #1 Wr_Hi = 1'b0; Wr_Lo = 1'b0;
        start_op(2'd2, 32'd100, 32'd7);
        saw_busy = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            saw_busy |= Busy;
            saw_done |= Done;
        end
        n_tests++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL nodiv_busy got %b want 0", saw_busy); end
        n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL nodiv_done got %b want 0", saw_done); end
        n_tests++; if ({HI, LO} !== {32'h11, 32'h11}) begin n_fail++; $display("FAIL nodiv_hilo got %h want %h", {HI, LO}, {32'h11, 32'h11}); end
        start_op(2'd0, 32'd3, 32'd5);
        wait_done(done_at, busy_cnt);
        n_tests++; if (LO !== 32'd15) begin n_fail++; $display("FAIL nodiv_mul_after got %h want f", LO); end
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_in_run;
        test_reset_mid_run;
        test_wr_hilo;
        test_back_to_back;
`ifndef MULDIV_DIV_EN
        test_div_disabled;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS core. It sequences 32-iteration shift-add multiplication and restoring division so the combinational 32×32 multiplier can be removed from the ALU path. It sits beside the ALU in the execute stage. Hazard logic stalls MFHI/MFLO and new MULT/DIV issues while `Busy` is high.

## Interface
Parameters:
- none (widths fixed at 32/64)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- Start  in  1  request an operation; sampled only in IDLE or DONE
- Op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A  in  32  multiplicand / dividend
- B  in  32  multiplier / divisor
- Wr_Hi  in  1  MTHI write strobe
- Wr_Lo  in  1  MTLO write strobe
- WD  in  32  MTHI/MTLO write data
- Busy  out  1  high in RUN and FIX
- Done  out  1  one-cycle pulse in DONE; HI/LO hold the new result
- HI  out  32  HI register (remainder / product[63:32])
- LO  out  32  LO register (quotient / product[31:0])

## Operation
- States: IDLE, RUN, FIX, DONE.
  - IDLE or DONE with Start=1 → RUN. Latch Op, sign flags, |A| and |B| (magnitudes only for signed ops), and clear the counter.
  - DONE with Start=0 → IDLE.
  - RUN iterates once per cycle. After the 32nd iteration → FIX.
  - FIX applies sign correction, writes HI/LO, then → DONE.
- Multiply: 64-bit accumulator, shift-add, one multiplier bit per iteration. Signed: negate the 64-bit product if sign(A) xor sign(B). Result: HI = product[63:32], LO = product[31:0].
- Divide: restoring, one quotient bit per iteration on a 33-bit partial remainder. Signed: quotient sign = sign(A) xor sign(B); remainder sign = sign(A). Result: LO = quotient, HI = remainder.
- Divide by zero (B=0) has a defined result: LO=0xFFFFFFFF, HI=A. This holds for both signed and unsigned. The signed quotient-sign fix is not applied in this case.
- Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of the magnitude arithmetic.
- Wr_Hi / Wr_Lo:
  - Applied in IDLE and DONE: register takes WD at the next edge.
  - Ignored in RUN and FIX.
  - Write and Start in the same cycle: the write lands first, then the result overwrites it at FIX.
- Start in RUN or FIX is ignored; no queueing.

## Timing
- Start sampled at edge k:
  - RUN after k.
  - Iterations at edges k+1 … k+32.
  - FIX after k+32.
  - HI/LO written at k+33.
  - Done=1 in the cycle after k+33.
- Total latency: 33 edges from Start to a valid HI/LO. Busy is high for 33 cycles.
- Back-to-back: Start in DONE begins the next op with no IDLE bubble.
- Reset (any time, including mid-RUN): state=IDLE, HI=0, LO=0, Busy=0, Done=0, counter=0. Any in-flight result is discarded.

## Configuration
- `MULDIV_DIV_EN` defined: full unit as above.
- Not defined:
  - Divider datapath is removed.
  - Start with Op[1]=1 is ignored: state stays IDLE or DONE→IDLE, Busy stays 0, no Done, HI/LO unchanged.
  - Multiply behaviour is unchanged.

## Structure
- Shared package `muldiv_pkg`:
  - Op encodings (MULDIV_MULTU/MULT/DIVU/DIV)
  - state enum
  - ITERATIONS = 32
  - divide-by-zero quotient constant 0xFFFFFFFF
- Sub-module `muldiv_step`: combinational single iteration. Inputs are mode, accumulator/remainder, and operand. Outputs are the next accumulator/remainder and the quotient bit. The top holds the FSM, counter, operand registers and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Done exactly 34 cycles after the Start cycle; Busy high 33 cycles.
- MULT 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2.
- DIVU 0x64 / 0 → HI=0x64, LO=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Start asserted during RUN → ignored, original result intact. rst asserted at iteration 10 → immediately Busy=0, HI=LO=0. Next MULTU 3×4 → LO=12.
- Wr_Lo with WD=0x1234 in IDLE → LO=0x1234 next cycle. Wr_Hi during RUN → HI unchanged. Start in DONE → new op with no bubble. Without `MULDIV_DIV_EN`, DIVU start → Busy stays 0.
